// File: rtl/if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_fetch_unit: instruction fetch stage (PC, icache requests, IF/ID feed)  |
// | Optional FETCH_PERF_EN adds saturating fetch / miss-cycle counters.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic        imembubble_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_miss_o
`endif
);

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_RUN   = 3'd1;
    localparam logic [2:0] C_ST_MISS  = 3'd2;
    localparam logic [2:0] C_ST_HOLD  = 3'd3;
    localparam logic [2:0] C_ST_DRAIN = 3'd4;

    logic [2:0]  state_q,  state_d;
    logic [31:0] pc_q,     pc_d;
    logic [31:0] hold_q,   hold_d;
    logic [31:0] target_q, target_d;

    logic [31:0] w_redir_pc;
    logic [31:0] w_pc_inc;
    logic        w_unused_bits;

    assign w_redir_pc    = {redirect_pc_i[31:2], 2'b00};
    assign w_pc_inc      = pc_q + 32'd4;
    assign w_unused_bits = ^redirect_pc_i[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= C_ST_IDLE;
            pc_q     <= RESET_PC;
            hold_q   <= 32'h0;
            target_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            hold_q   <= hold_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        hold_d   = hold_q;
        target_d = target_q;
        case (state_q)
            C_ST_IDLE: begin
                state_d = C_ST_RUN;
                if (redirect_i) pc_d = w_redir_pc;
            end
            C_ST_RUN, C_ST_MISS: begin
                if (redirect_i) begin
                    // Without an ack the request is still in flight and must complete first.
                    if (imem_ack_i) begin
                        pc_d    = w_redir_pc;
                        state_d = C_ST_RUN;
                    end else begin
                        target_d = w_redir_pc;
                        state_d  = C_ST_DRAIN;
                    end
                end else if (imem_ack_i) begin
                    if (stall_i) begin
                        hold_d  = imem_data_i;
                        state_d = C_ST_HOLD;
                    end else begin
                        pc_d    = w_pc_inc;
                        state_d = C_ST_RUN;
                    end
                end else begin
                    state_d = C_ST_MISS;
                end
            end
            C_ST_HOLD: begin
                if (redirect_i) begin
                    pc_d    = w_redir_pc;
                    state_d = C_ST_RUN;
                end else if (!stall_i) begin
                    pc_d    = w_pc_inc;
                    state_d = C_ST_RUN;
                end
            end
            C_ST_DRAIN: begin
                if (imem_ack_i) begin
                    pc_d    = redirect_i ? w_redir_pc : target_q;
                    state_d = C_ST_RUN;
                end else if (redirect_i) begin
                    target_d = w_redir_pc;
                end
            end
            default: state_d = C_ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req_o    = 1'b0;
        instruction_o = 32'h0;
        imembubble_o  = 1'b1;
        case (state_q)
            C_ST_RUN, C_ST_MISS: begin
                imem_req_o = 1'b1;
                if (imem_ack_i && !redirect_i) begin
                    instruction_o = imem_data_i;
                    imembubble_o  = 1'b0;
                end
            end
            C_ST_HOLD: begin
                if (!redirect_i) begin
                    instruction_o = hold_q;
                    imembubble_o  = 1'b0;
                end
            end
            C_ST_DRAIN: imem_req_o = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr_o = pc_q;
    assign pc_o        = pc_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_miss_q;
    logic        w_accept;
    logic        w_miss_cycle;

    assign w_accept     = !imembubble_o && !stall_i && !redirect_i;
    assign w_miss_cycle = (state_q == C_ST_MISS) || (state_q == C_ST_DRAIN);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            perf_fetch_q <= 32'h0;
            perf_miss_q  <= 32'h0;
        end else begin
            if (w_accept && (perf_fetch_q != 32'hFFFF_FFFF))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (w_miss_cycle && (perf_miss_q != 32'hFFFF_FFFF))
                perf_miss_q <= perf_miss_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_miss_o  = perf_miss_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_fetch_unit: scoreboard bench for if_fetch_unit                      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_if_fetch_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] idata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bubble;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_miss;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc;
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(C_RESET_PC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .stall_i       (stall),
        .redirect_i    (redir),
        .redirect_pc_i (rpc),
        .imem_req_o    (req),
        .imem_addr_o   (addr),
        .imem_ack_i    (ack),
        .imem_data_i   (idata),
        .pc_o          (pc),
        .instruction_o (instr),
        .imembubble_o  (bubble)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_o  (perf_fetch),
        .perf_miss_o   (perf_miss)
`endif
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    always_comb idata = ack ? mem_f(addr) : 32'hDEAD_BEEF;

    task automatic push_exp(input logic [31:0] a);
        q_pc.push_back(a);
        q_ins.push_back(mem_f(a));
    endtask

    // One cycle: drive inputs at the falling edge, sample 1ns later, retire accepted instructions.
    task automatic step(input logic st, input logic rd, input logic [31:0] rp, input logic ak);
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        @(negedge clk);
        stall = st; redir = rd; rpc = rp; ack = ak;
        #1;
        if (bubble === 1'b1) begin
            checks++;
            if (instr !== 32'h0) begin
                errors++; $display("FAIL bubble_instr_zero: got %h want 00000000", instr);
            end
        end else if (!st && !rd) begin
            checks++;
            if (q_pc.size() == 0) begin
                errors++; $display("FAIL sb_unexpected: got pc %h instr %h bubble %b, want none", pc, instr, bubble);
            end else begin
                e_pc  = q_pc.pop_front();
                e_ins = q_ins.pop_front();
                if (pc !== e_pc || instr !== e_ins) begin
                    errors++; $display("FAIL sb_fetch: got pc %h instr %h want pc %h instr %h", pc, instr, e_pc, e_ins);
                end
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = 32'h0; ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (req !== 1'b0 || addr !== C_RESET_PC || pc !== C_RESET_PC || instr !== 32'h0 || bubble !== 1'b1) begin
            errors++; $display("FAIL reset_outputs: got req %b addr %h pc %h instr %h bubble %b want 0 %h %h 0 1", req, addr, pc, instr, bubble, C_RESET_PC, C_RESET_PC);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req !== 1'b0 || bubble !== 1'b1) begin
            errors++; $display("FAIL idle_cycle: got req %b bubble %b want 0 1", req, bubble);
        end
        exp_pc = C_RESET_PC;
    endtask

    task automatic test_hits;
        for (int i = 0; i < 3; i++) begin
            push_exp(exp_pc);
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (req !== 1'b1 || addr !== exp_pc) begin
                errors++; $display("FAIL hit_addr: got req %b addr %h want 1 %h", req, addr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_miss;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
            checks++;
            if (req !== 1'b1 || addr !== exp_pc || bubble !== 1'b1) begin
                errors++; $display("FAIL miss_wait: got req %b addr %h bubble %b want 1 %h 1", req, addr, bubble, exp_pc);
            end
        end
        for (int i = 0; i < 2; i++) begin
            push_exp(exp_pc);
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (addr !== exp_pc) begin
                errors++; $display("FAIL miss_resume_addr: got %h want %h", addr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_stall;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bubble !== 1'b0 || instr !== mem_f(exp_pc)) begin
            errors++; $display("FAIL stall_present: got bubble %b instr %h want 0 %h", bubble, instr, mem_f(exp_pc));
        end
        step(1'b1, 1'b0, 32'h0, 1'b0);
        checks++;
        if (req !== 1'b0 || bubble !== 1'b0 || instr !== mem_f(exp_pc) || pc !== exp_pc) begin
            errors++; $display("FAIL hold_present: got req %b bubble %b instr %h pc %h want 0 0 %h %h", req, bubble, instr, pc, mem_f(exp_pc), exp_pc);
        end
        push_exp(exp_pc);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        exp_pc = exp_pc + 32'd4;
        push_exp(exp_pc);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (req !== 1'b1 || addr !== exp_pc) begin
            errors++; $display("FAIL hold_release_addr: got req %b addr %h want 1 %h", req, addr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_redirect_drain;
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        checks++;
        if (bubble !== 1'b1) begin
            errors++; $display("FAIL redirect_ack_bubble: got %b want 1", bubble);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0402, 1'b0);
        checks++;
        if (req !== 1'b1 || addr !== 32'h200 || bubble !== 1'b1) begin
            errors++; $display("FAIL redirect_miss: got req %b addr %h bubble %b want 1 00000200 1", req, addr, bubble);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (req !== 1'b1 || addr !== 32'h200) begin
            errors++; $display("FAIL drain_hold_addr: got req %b addr %h want 1 00000200", req, addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (bubble !== 1'b1 || addr !== 32'h200) begin
            errors++; $display("FAIL drain_discard: got bubble %b addr %h want 1 00000200", bubble, addr);
        end
        exp_pc = 32'h400;
        push_exp(exp_pc);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (addr !== 32'h400) begin
            errors++; $display("FAIL drain_target: got %h want 00000400", addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0500, 1'b0);
        step(1'b0, 1'b1, 32'h0000_0603, 1'b1);
        checks++;
        if (bubble !== 1'b1 || addr !== 32'h404) begin
            errors++; $display("FAIL drain_redirect_ack: got bubble %b addr %h want 1 00000404", bubble, addr);
        end
        exp_pc = 32'h600;
        push_exp(exp_pc);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (addr !== 32'h600) begin
            errors++; $display("FAIL drain_new_target: got %h want 00000600", addr);
        end
        exp_pc = 32'h604;
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        exp_pc = 32'hFFFF_FFFC;
        for (int i = 0; i < 2; i++) begin
            push_exp(exp_pc);
            step(1'b0, 1'b0, 32'h0, 1'b1);
            checks++;
            if (addr !== exp_pc) begin
                errors++; $display("FAIL wrap_addr: got %h want %h", addr, exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_hold_redirect;
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h0000_0300, 1'b0);
        checks++;
        if (bubble !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL hold_redirect: got bubble %b req %b want 1 0", bubble, req);
        end
        exp_pc = 32'h300;
        push_exp(exp_pc);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (addr !== 32'h300) begin
            errors++; $display("FAIL hold_redirect_addr: got %h want 00000300", addr);
        end
        exp_pc = 32'h304;
    endtask

    task automatic test_back_to_back;
        logic in_hold;
        logic ak;
        logic st;
        in_hold = 1'b0;
        for (int i = 0; i < 60; i++) begin
            ak = 1'($urandom_range(0, 1));
            st = ($urandom_range(0, 3) == 0);
            if (!in_hold && ak) push_exp(exp_pc);
            step(st, 1'b0, 32'h0, ak);
            checks++;
            if (req !== !in_hold || (!in_hold && addr !== exp_pc)) begin
                errors++; $display("FAIL b2b_req: got req %b addr %h want %b %h", req, addr, !in_hold, exp_pc);
            end
            if (!in_hold) begin
                if (ak) begin
                    if (st) in_hold = 1'b1;
                    else    exp_pc = exp_pc + 32'd4;
                end
            end else if (!st) begin
                exp_pc  = exp_pc + 32'd4;
                in_hold = 1'b0;
            end
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_hits();
        test_miss();
        test_stall();
        test_redirect_drain();
        test_wrap();
        test_hold_redirect();
        test_back_to_back();
        checks++;
        if (q_pc.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d pending want 0", q_pc.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
